t5_load: RTL

Load-return stage of the tra5 data path, directly downstream of the data-bus request stage. Consumes the registered bus strobe/write/byte-select and misalignment flag produced by that stage, waits for the Wishbone data acknowledge, and stalls the pipeline while the access is outstanding. Extracts and sign/zero-extends the returned load data per funct3, then presents it with its destination register to writeback. Flags misaligned accesses and, optionally, bus timeouts.

---
 rtl/t5_load.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/t5_load.sv
// t5_load: tra5 load-return stage. Waits for the Wishbone ack, stalls the pipeline and extends the load data.
// Optional bus timeout: define T5_LOAD_TOUT_EN (limit set by parameter TOUT).
module t5_load #(
    parameter int unsigned TOUT = 16
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic        sena,
    input  logic [2:0]  dfn3,
    input  logic [4:0]  drd,
    input  logic [1:0]  xstb,
    input  logic        xwre,
    input  logic [3:0]  xsel,
    input  logic [31:0] dwb_dti,
    input  logic        dwb_ack,
    output logic        mstall,
    output logic [31:0] mdat,
    output logic [4:0]  mrd,
    output logic        mwre,
    output logic        mmis,
    output logic        mberr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [2:0]  r_xfn3;
    logic [4:0]  r_xrd;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [31:0] r_mdat;
    logic [4:0]  r_mrd;
    logic        r_mwre;
    logic        r_mmis;
    logic        w_req_vld;
    logic        w_cap;
    logic        w_tout_hit;
    logic        w_sext;
    logic [31:0] w_ldat;

    assign w_req_vld = (xstb == 2'b10);
    assign w_cap     = w_req_vld && dwb_ack;
    assign mstall    = w_req_vld && !dwb_ack && !w_tout_hit;

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_xfn3 <= '0;
            r_xrd  <= '0;
        end else if (sena) begin
            r_xfn3 <= dfn3;
            r_xrd  <= drd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req_vld && !dwb_ack && !w_tout_hit) w_state_nxt = ST_WAIT;
            ST_WAIT: if (!w_req_vld || dwb_ack || w_tout_hit) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // funct3[2] selects zero extension; the low funct3 bits are implied by xsel.
    always_comb begin
        w_sext = ~r_xfn3[2];
        w_ldat = '0;
        case (xsel)
            4'h1:    w_ldat = {{24{w_sext & dwb_dti[7]}},  dwb_dti[7:0]};
            4'h2:    w_ldat = {{24{w_sext & dwb_dti[15]}}, dwb_dti[15:8]};
            4'h4:    w_ldat = {{24{w_sext & dwb_dti[23]}}, dwb_dti[23:16]};
            4'h8:    w_ldat = {{24{w_sext & dwb_dti[31]}}, dwb_dti[31:24]};
            4'h3:    w_ldat = {{16{w_sext & dwb_dti[15]}}, dwb_dti[15:0]};
            4'hC:    w_ldat = {{16{w_sext & dwb_dti[31]}}, dwb_dti[31:16]};
            4'hF:    w_ldat = dwb_dti;
            default: w_ldat = '0;
        endcase
    end

    logic w_unused_fn3;
    assign w_unused_fn3 = ^r_xfn3[1:0];

    // Stores complete on ack without touching the writeback data.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_mdat <= '0;
            r_mrd  <= '0;
            r_mwre <= 1'b0;
            r_mmis <= 1'b0;
        end else begin
            r_mwre <= w_cap && !xwre;
            r_mmis <= (xstb == 2'b11);
            if (w_cap && !xwre) begin
                r_mdat <= w_ldat;
                r_mrd  <= r_xrd;
            end
        end
    end

    assign mdat = r_mdat;
    assign mrd  = r_mrd;
    assign mwre = r_mwre;
    assign mmis = r_mmis;

`ifdef T5_LOAD_TOUT_EN
    localparam int unsigned   CW       = $clog2(TOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_mberr;

    // Counter runs on every stalled request cycle, so the limit includes the first (IDLE) cycle.
    assign w_tout_hit = w_req_vld && (r_cnt == CNT_LAST) && !dwb_ack;

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_cnt   <= '0;
            r_mberr <= 1'b0;
        end else begin
            r_mberr <= w_tout_hit;
            if (!w_req_vld || dwb_ack || w_tout_hit) r_cnt <= '0;
            else                                     r_cnt <= r_cnt + CW'(1);
        end
    end

    assign mberr = r_mberr;
`else
    localparam logic [31:0] UNUSED_TOUT = 32'(TOUT);

    logic w_unused_tout;
    assign w_unused_tout = UNUSED_TOUT[0];
    assign w_tout_hit    = 1'b0;
    assign mberr         = 1'b0;
`endif

endmodule
